// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM request controller: request/response records at the
// default macro widths and the controller state encoding.
package sram_ctrl_pkg;

  localparam int CTRL_DW = 128;
  localparam int CTRL_AW = 9;
  localparam int CTRL_IW = 4;
  localparam int CTRL_BW = CTRL_DW / 8;

  typedef struct packed {
    logic               wr;
    logic [CTRL_BW-1:0] be;
    logic [CTRL_AW-1:0] addr;
    logic [CTRL_DW-1:0] wdata;
    logic [CTRL_IW-1:0] id;
  } sram_req_t;

  typedef struct packed {
    logic [CTRL_DW-1:0] rdata;
    logic [CTRL_IW-1:0] id;
  } sram_rsp_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO for read responses; the head is read straight out of the
// storage registers so it holds steady while the consumer stalls.
module sram_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/sram_req_ctrl.sv
// Initiator-side controller for a single-port byte-enabled SRAM: optional zero-fill
// after reset, then request issue with credit-limited, in-order read responses.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 9,
  parameter int ID_WIDTH   = 4,
  parameter int RSP_DEPTH  = 4,
  parameter int INIT_EN    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [ID_WIDTH-1:0]     req_id,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ID_WIDTH-1:0]     rsp_id,
  output logic                    mem_en,
  output logic                    mem_wr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    init_done
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int FW = DATA_WIDTH + ID_WIDTH;

  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_ptr_q, init_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  s1_valid_q;
  logic [ID_WIDTH-1:0]   s1_id_q;

  logic          credit_ok;
  logic          accept;
  logic          rd_accept;
  logic          rsp_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == ST_INIT) begin
      init_ptr_d = init_ptr_q + 1'b1;
      if (&init_ptr_q) state_d = ST_RUN;
    end
  end

  // Every valid-type output is gated by rst_n so nothing leaks onto the port during reset.
  always_comb begin
    req_ready = 1'b0;
    init_done = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_be    = '0;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    if (rst_n) begin
      case (state_q)
        ST_INIT: begin
          mem_en    = 1'b1;
          mem_wr    = 1'b1;
          mem_be    = '1;
          mem_addr  = init_ptr_q;
          mem_wdata = '0;
        end
        ST_RUN: begin
          init_done = 1'b1;
          req_ready = credit_ok;
          mem_en    = req_valid && credit_ok;
          mem_wr    = req_wr;
          mem_be    = req_wr ? req_be : '1;
        end
        default: ;
      endcase
    end
  end

  assign credit_ok = (cnt_q < CW'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_wr;
  assign rsp_pop   = rsp_valid && rsp_ready;

  always_comb begin
    cnt_d = cnt_q;
    case ({rd_accept, rsp_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Stage s1 tracks the read whose data the SRAM presents on the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= rd_accept;
      s1_id_q    <= req_id;
      cnt_q      <= cnt_d;
    end
  end

  sram_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (s1_valid_q),
    .data_i  ({mem_rdata, s1_id_q}),
    .pop_i   (rsp_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign rsp_valid = rst_n && !fifo_empty;
  assign rsp_rdata = fifo_head[FW-1:ID_WIDTH];
  assign rsp_id    = fifo_head[ID_WIDTH-1:0];

  // Credits bound buffered reads, so a push into a full FIFO means the credit logic is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(s1_valid_q && fifo_full && !rsp_pop));

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Randomised and directed checks of sram_req_ctrl against a transaction-level
// model (golden memory array plus an ordered expected-response queue).
module tb_sram_req_ctrl;

  localparam int DW    = 128;
  localparam int AW    = 4;
  localparam int IW    = 4;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 4;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [BW-1:0] req_be;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [IW-1:0] req_id;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [IW-1:0] rsp_id;
  logic          mem_en;
  logic          mem_wr;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          init_done;

  always #5 clk = ~clk;

  sram_req_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ID_WIDTH   (IW),
    .RSP_DEPTH  (DEPTH),
    .INIT_EN    (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_id    (req_id),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_id    (rsp_id),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .init_done (init_done)
  );

  // SRAM macro stand-in: registered read, junk on the data bus whenever no read was issued.
  logic [DW-1:0] sram [WORDS];
  logic          sram_filled = 1'b0;

  always @(posedge clk) begin
    if (!sram_filled) begin
      for (int i = 0; i < WORDS; i++) sram[i] <= {$urandom(), $urandom(), $urandom(), $urandom()};
      sram_filled <= 1'b1;
    end
    if (mem_en && mem_wr) begin
      for (int b = 0; b < BW; b++)
        if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    if (mem_en && !mem_wr) mem_rdata <= sram[mem_addr];
    else                   mem_rdata <= {$urandom(), $urandom(), $urandom(), $urandom()};
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 50)
        $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Behavioural model state
  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] id;
    int            t;
  } exp_t;

  logic [DW-1:0] gold [WORDS];
  exp_t          exp_q[$];
  int            outstanding = 0;
  int            init_left   = WORDS;
  int            cyc         = 0;
  logic [DW-1:0] got_d  [256];
  logic [IW-1:0] got_id [256];
  int            got_n  = 0;

  task automatic mon_step();
    logic exp_done, exp_ready, exp_rv, acc;
    cyc++;
    if (!rst_n) begin
      chk("rst_req_ready", DW'(req_ready), '0);
      chk("rst_rsp_valid", DW'(rsp_valid), '0);
      chk("rst_mem_en",    DW'(mem_en),    '0);
      chk("rst_init_done", DW'(init_done), '0);
      exp_q.delete();
      outstanding = 0;
      init_left   = WORDS;
      for (int i = 0; i < WORDS; i++) gold[i] = '0;
      return;
    end
    exp_done  = (init_left == 0);
    exp_ready = exp_done && (outstanding < DEPTH);
    exp_rv    = (exp_q.size() > 0) && (exp_q[0].t + 2 <= cyc);
    chk("init_done", DW'(init_done), DW'(exp_done));
    chk("req_ready", DW'(req_ready), DW'(exp_ready));
    chk("rsp_valid", DW'(rsp_valid), DW'(exp_rv));
    chk("credit_cnt", DW'(dut.cnt_q), DW'(outstanding));
    if (!exp_done) begin
      chk("init_mem_en",    DW'(mem_en),    DW'(1));
      chk("init_mem_wr",    DW'(mem_wr),    DW'(1));
      chk("init_mem_be",    DW'(mem_be),    DW'({BW{1'b1}}));
      chk("init_mem_addr",  DW'(mem_addr),  DW'(WORDS - init_left));
      chk("init_mem_wdata", mem_wdata,      '0);
    end else begin
      acc = req_valid && exp_ready;
      chk("run_mem_en", DW'(mem_en), DW'(acc));
      if (acc) begin
        chk("run_mem_wr",   DW'(mem_wr),   DW'(req_wr));
        chk("run_mem_addr", DW'(mem_addr), DW'(req_addr));
        chk("run_mem_be",   DW'(mem_be),   DW'(req_wr ? req_be : {BW{1'b1}}));
        if (req_wr) chk("run_mem_wdata", mem_wdata, req_wdata);
      end
    end
    if (exp_rv) begin
      chk("rsp_rdata", rsp_rdata, exp_q[0].d);
      chk("rsp_id",    DW'(rsp_id), DW'(exp_q[0].id));
    end
    if (init_left > 0) init_left--;
    if (exp_rv && rsp_ready) begin
      $display("rsp id=%0d data=%h", rsp_id, rsp_rdata);
      got_d[got_n % 256]  = rsp_rdata;
      got_id[got_n % 256] = rsp_id;
      got_n++;
      void'(exp_q.pop_front());
      outstanding--;
    end
    if (exp_done && req_valid && exp_ready) begin
      if (req_wr) begin
        $display("req wr addr=%0d be=%h data=%h", req_addr, req_be, req_wdata);
        for (int b = 0; b < BW; b++)
          if (req_be[b]) gold[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
      end else begin
        $display("req rd addr=%0d id=%0d", req_addr, req_id);
        exp_q.push_back('{d: gold[req_addr], id: req_id, t: cyc});
        outstanding++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit wr, input int addr, input logic [DW-1:0] d,
                      input logic [BW-1:0] be, input int id);
    int n = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = AW'(addr);
    req_wdata = d;
    req_be    = be;
    req_id    = IW'(id);
    while (!req_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("send_timeout", DW'(n), '0);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp_head(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, base, lat, cmax;
    bit acc;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_be = '0; req_addr = '0;
    req_wdata = '0; req_id = '0; rsp_ready = 1'b1;
    repeat (3) step();
    chk("reset_req_ready", DW'(req_ready), '0);
    chk("reset_mem_en",    DW'(mem_en),    '0);
    chk("reset_init_done", DW'(init_done), '0);

    // Zero-fill lasts one cycle per word
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 100) begin
      step();
      n++;
    end
    chk("init_cycles", DW'(n), DW'(16));

    base = got_n;
    for (int i = 0; i < WORDS; i++) send(1'b0, i, '0, '0, i);
    n = 0;
    while (got_n - base < WORDS && n < 100) begin step(); n++; end
    for (int i = 0; i < WORDS; i++) begin
      chk("init_zero_data", got_d[(base + i) % 256], '0);
      chk("init_zero_id",   DW'(got_id[(base + i) % 256]), DW'(i));
    end

    // Read-after-write to the same word, two-cycle response latency
    send(1'b1, 5, {16{8'hAA}}, 16'hFFFF, 0);
    send(1'b0, 5, '0, '0, 3);
    wait_rsp_head(lat);
    chk("raw_latency", DW'(lat), DW'(2));
    chk("raw_rdata",   rsp_rdata, {16{8'hAA}});
    chk("raw_id",      DW'(rsp_id), DW'(3));
    step();

    // Byte-enable merge
    send(1'b1, 7, {DW{1'b1}}, 16'hFFFF, 0);
    send(1'b1, 7, '0, 16'h0001, 0);
    send(1'b0, 7, '0, '0, 1);
    wait_rsp_head(lat);
    chk("be_merge_rdata", rsp_rdata, {{15{8'hFF}}, 8'h00});
    step();
    repeat (3) step();

    // Backpressure: only RSP_DEPTH reads can be outstanding
    base = got_n;
    rsp_ready = 1'b0;
    k = 0;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    repeat (10) begin
      req_addr = AW'(k);
      req_id   = IW'(k);
      acc = req_ready;
      step();
      if (acc) k++;
    end
    chk("bp_accepted", DW'(k), DW'(4));
    chk("bp_req_ready_low", DW'(req_ready), '0);
    rsp_ready = 1'b1;
    n = 0;
    while (k < 6 && n < 50) begin
      req_addr = AW'(k);
      req_id   = IW'(k);
      acc = req_ready;
      step();
      if (acc) k++;
      n++;
    end
    req_valid = 1'b0;
    n = 0;
    while (got_n - base < 6 && n < 50) begin step(); n++; end
    chk("bp_rsp_count", DW'(got_n - base), DW'(6));
    for (int i = 0; i < 6; i++) chk("bp_order_id", DW'(got_id[(base + i) % 256]), DW'(i));

    // Streaming reads at one per cycle
    base = got_n;
    k = 0; n = 0; cmax = 0;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    while (k < 20 && n < 100) begin
      req_addr = AW'(k % 16);
      req_id   = IW'(k % 16);
      acc = req_ready;
      step();
      n++;
      if (acc) k++;
      if (int'(dut.cnt_q) > cmax) cmax = int'(dut.cnt_q);
    end
    req_valid = 1'b0;
    chk("stream_cycles", DW'(n), DW'(20));
    n = 0;
    while (got_n - base < 20 && n < 50) begin
      step();
      n++;
      if (int'(dut.cnt_q) > cmax) cmax = int'(dut.cnt_q);
    end
    chk("stream_rsp_count", DW'(got_n - base), DW'(20));
    chk("stream_cnt_max",   DW'(cmax), DW'(2));

    // Reset while a read is in flight
    base = got_n;
    send(1'b0, 5, '0, '0, 9);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_init_done", DW'(init_done), '0);
    chk("midrst_cnt",       DW'(dut.cnt_q), '0);
    chk("midrst_rsp_valid", DW'(rsp_valid), '0);
    n = 0;
    while (!init_done && n < 100) begin step(); n++; end
    chk("midrst_init_cycles", DW'(n), DW'(16));
    chk("midrst_no_rsp",      DW'(got_n - base), '0);
    send(1'b0, 5, '0, '0, 2);
    wait_rsp_head(lat);
    chk("midrst_rezero_rdata", rsp_rdata, '0);
    chk("midrst_rezero_id",    DW'(rsp_id), DW'(2));
    step();

    // Randomised traffic with random response backpressure
    acc = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (acc || !req_valid) begin
        req_valid = ($urandom_range(0, 9) < 7);
        req_wr    = ($urandom_range(0, 2) == 0);
        req_addr  = AW'($urandom_range(0, WORDS - 1));
        req_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        req_be    = BW'($urandom());
        req_id    = IW'($urandom());
      end
      rsp_ready = ($urandom_range(0, 9) < 6);
      acc = req_valid && req_ready;
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (outstanding > 0 && n < 50) begin step(); n++; end
    chk("drain_outstanding", DW'(outstanding), '0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
